// File: rtl/div_unit_pkg.sv
// Shared defines for the iterative divider: FSM encodings and handshake constants.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dividend_msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem_i < divisor_i keeps both the shifted value and a non-negative trial in range
  assign shifted = {rem_i, dividend_msb_i};
  assign trial   = shifted - {1'b0, divisor_i};
  assign q_o     = ~trial[WIDTH];
  assign rem_o   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Iterative signed/unsigned restoring divider; quotient in the low half of result_o, remainder in the high half.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  div_state_e state_q, state_d;

  logic [WIDTH-1:0]   dividend_q, dividend_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  logic               sign1, sign2;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH-1:0]   rem_next;
  logic               q_bit;
  logic [WIDTH-1:0]   q_raw, q_fix, r_fix;
  logic               last;

  assign sign1 = signed_i & opdata1_i[WIDTH-1];
  assign sign2 = signed_i & opdata2_i[WIDTH-1];
  assign abs1  = sign1 ? -opdata1_i : opdata1_i;
  assign abs2  = sign2 ? -opdata2_i : opdata2_i;
  assign last  = (cnt_q == CNT_W'(WIDTH - 1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i          (rem_q),
    .dividend_msb_i (dividend_q[WIDTH-1]),
    .divisor_i      (divisor_q),
    .rem_o          (rem_next),
    .q_o            (q_bit)
  );

  // dividend register doubles as the quotient shift register
  assign q_raw = {dividend_q[WIDTH-2:0], q_bit};
  assign q_fix = neg_q_q ? -q_raw : q_raw;
  assign r_fix = neg_r_q ? -rem_next : rem_next;

  always_ff @(posedge clk) begin
    if (rst) state_q <= DIV_FREE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_FREE:   if (start_i == DivStart) state_d = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
      DIV_BYZERO: state_d = DIV_END;
      DIV_ON:     if (last) state_d = DIV_END;
      DIV_END:    if (start_i == DivStop) state_d = DIV_FREE;
      default:    state_d = DIV_FREE;
    endcase
    if (annul_i) state_d = DIV_FREE;
  end

  always_comb begin
    ready_d    = (state_d == DIV_END) ? DivResultReady : DivResultNotReady;
    busy_d     = (state_d == DIV_BYZERO) || (state_d == DIV_ON);
    result_d   = result_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    case (state_q)
      DIV_FREE: begin
        if (state_d != DIV_FREE) begin
          dividend_d = abs1;
          divisor_d  = abs2;
          rem_d      = '0;
          cnt_d      = '0;
          neg_q_d    = sign1 ^ sign2;
          neg_r_d    = sign1;
        end
      end
      DIV_BYZERO: if (!annul_i) result_d = '0;
      DIV_ON: begin
        dividend_d = q_raw;
        rem_d      = rem_next;
        cnt_d      = cnt_q + CNT_W'(1);
        if (last && !annul_i) result_d = {r_fix, q_fix};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      result_q   <= '0;
      ready_q    <= DivResultNotReady;
      busy_q     <= 1'b0;
    end else begin
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: 32-bit and 8-bit instances against an arithmetic reference (/ and %).
module tb_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        st32 = 0, sg32 = 0, an32 = 0;
  logic [31:0] a32 = 0, b32 = 0;
  logic [63:0] res32;
  logic        rdy32, bsy32;

  logic        st8 = 0, sg8 = 0, an8 = 0;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [15:0] res8;
  logic        rdy8, bsy8;

  int total = 0;
  int bad = 0;

  div_unit #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .start_i(st32), .signed_i(sg32),
    .opdata1_i(a32), .opdata2_i(b32), .annul_i(an32),
    .result_o(res32), .ready_o(rdy32), .busy_o(bsy32)
  );

  div_unit #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start_i(st8), .signed_i(sg8),
    .opdata1_i(a8), .opdata2_i(b8), .annul_i(an8),
    .result_o(res8), .ready_o(rdy8), .busy_o(bsy8)
  );

  function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic sg);
    longint x, y, q, r;
    if (b == 32'd0) return 64'd0;
    if (sg) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic sg);
    int x, y, q, r;
    if (b == 8'd0) return 16'd0;
    if (sg) begin
      x = int'($signed(a));
      y = int'($signed(b));
    end else begin
      x = int'({24'd0, a});
      y = int'({24'd0, b});
    end
    q = x / y;
    r = x % y;
    return {r[7:0], q[7:0]};
  endfunction

  // Drives one operation; entered and left just after a rising edge.
  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic sg,
                       output logic [63:0] res, output int lat, output int bcnt);
    st32 = 1; sg32 = sg; a32 = a; b32 = b; lat = 0; bcnt = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (bsy32) bcnt++;
    end while (!rdy32 && lat < 100);
    res = res32;
    st32 = 0;
    @(posedge clk); #1;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sg,
                      output logic [15:0] res, output int lat);
    st8 = 1; sg8 = sg; a8 = a; b8 = b; lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!rdy8 && lat < 100);
    res = res8;
    st8 = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    total += 6;
    if (res32 !== 64'd0) begin bad++; $display("FAIL reset_res32 got=%h exp=0", res32); end
    if (rdy32 !== 1'b0) begin bad++; $display("FAIL reset_rdy32 got=%b exp=0", rdy32); end
    if (bsy32 !== 1'b0) begin bad++; $display("FAIL reset_bsy32 got=%b exp=0", bsy32); end
    if (res8 !== 16'd0) begin bad++; $display("FAIL reset_res8 got=%h exp=0", res8); end
    if (rdy8 !== 1'b0) begin bad++; $display("FAIL reset_rdy8 got=%b exp=0", rdy8); end
    if (bsy8 !== 1'b0) begin bad++; $display("FAIL reset_bsy8 got=%b exp=0", bsy8); end
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] a [4] = '{32'd100, -32'sd100, 32'd100, 32'h8000_0000};
    logic [31:0] b [4] = '{32'd7, 32'd7, -32'sd7, 32'hFFFF_FFFF};
    logic        s [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [63:0] e [4] = '{64'h00000002_0000000E, 64'hFFFFFFFE_FFFFFFF2,
                           64'h00000002_FFFFFFF2, 64'h00000000_80000000};
    logic [63:0] res;
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      run32(a[i], b[i], s[i], res, lat, bc);
      total += 4;
      if (res !== e[i]) begin bad++; $display("FAIL dir%0d_res got=%h exp=%h", i, res, e[i]); end
      if (lat !== 33) begin bad++; $display("FAIL dir%0d_lat got=%0d exp=33", i, lat); end
      if (bc !== 32) begin bad++; $display("FAIL dir%0d_busy got=%0d exp=32", i, bc); end
      if (rdy32 !== 1'b0) begin bad++; $display("FAIL dir%0d_rdy_drop got=%b exp=0", i, rdy32); end
    end
  endtask

  task automatic test_byzero();
    logic [63:0] res;
    int lat, bc;
    for (int i = 0; i < 2; i++) begin
      run32(32'h1234 + i, 32'd0, i[0], res, lat, bc);
      total += 3;
      if (res !== 64'd0) begin bad++; $display("FAIL byzero%0d_res got=%h exp=0", i, res); end
      if (lat !== 2) begin bad++; $display("FAIL byzero%0d_lat got=%0d exp=2", i, lat); end
      if (bc !== 1) begin bad++; $display("FAIL byzero%0d_busy got=%0d exp=1", i, bc); end
    end
  endtask

  task automatic test_annul();
    logic [63:0] prev, res;
    int lat, bc;
    run32(32'd500, 32'd9, 1'b0, prev, lat, bc);
    st32 = 1; sg32 = 0; a32 = 32'd1000; b32 = 32'd3;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      total++;
      if (rdy32 !== 1'b0) begin bad++; $display("FAIL annul_early_rdy cyc=%0d got=%b exp=0", i, rdy32); end
    end
    an32 = 1; st32 = 0;
    @(posedge clk); #1;
    total += 3;
    if (bsy32 !== 1'b0) begin bad++; $display("FAIL annul_busy got=%b exp=0", bsy32); end
    if (rdy32 !== 1'b0) begin bad++; $display("FAIL annul_rdy got=%b exp=0", rdy32); end
    if (res32 !== prev) begin bad++; $display("FAIL annul_res got=%h exp=%h", res32, prev); end
    an32 = 0;
    run32(32'hDEAD_BEEF, 32'd77, 1'b1, res, lat, bc);
    total += 2;
    if (res !== ref32(32'hDEAD_BEEF, 32'd77, 1'b1)) begin
      bad++; $display("FAIL annul_restart_res got=%h exp=%h", res, ref32(32'hDEAD_BEEF, 32'd77, 1'b1));
    end
    if (lat !== 33) begin bad++; $display("FAIL annul_restart_lat got=%0d exp=33", lat); end
    // annul beats start while idle
    an32 = 1; st32 = 1; a32 = 32'd81; b32 = 32'd9; sg32 = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (bsy32 !== 1'b0 || rdy32 !== 1'b0) begin
        bad++; $display("FAIL annul_prio busy=%b rdy=%b exp=0", bsy32, rdy32);
      end
    end
    an32 = 0; st32 = 0;
    run32(32'd81, 32'd9, 1'b0, res, lat, bc);
    total += 2;
    if (res !== 64'd9) begin bad++; $display("FAIL annul_prio_res got=%h exp=9", res); end
    if (lat !== 33) begin bad++; $display("FAIL annul_prio_lat got=%0d exp=33", lat); end
  endtask

  task automatic test_random32();
    logic [63:0] res, exp;
    logic [31:0] a, b;
    logic s;
    int lat, bc;
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if ($urandom_range(0, 3) == 0) b = -b;
      s = 1'($urandom_range(0, 1));
      exp = ref32(a, b, s);
      run32(a, b, s, res, lat, bc);
      total += 2;
      if (res !== exp) begin bad++; $display("FAIL rnd32_%0d_res a=%h b=%h s=%b got=%h exp=%h", i, a, b, s, res, exp); end
      if (lat !== ((b == 0) ? 2 : 33)) begin bad++; $display("FAIL rnd32_%0d_lat got=%0d", i, lat); end
    end
  endtask

  task automatic test_width8();
    logic [15:0] res, exp;
    logic [7:0] a, b;
    logic s;
    int lat;
    st8 = 1; sg8 = 0; a8 = 8'd255; b8 = 8'd16; lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!rdy8 && lat < 100);
    total += 2;
    if (lat !== 9) begin bad++; $display("FAIL w8_lat got=%0d exp=9", lat); end
    if (res8 !== 16'h0F0F) begin bad++; $display("FAIL w8_res got=%h exp=0f0f", res8); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (rdy8 !== 1'b1 || res8 !== 16'h0F0F) begin
        bad++; $display("FAIL w8_hold cyc=%0d rdy=%b res=%h exp rdy=1 res=0f0f", i, rdy8, res8);
      end
    end
    st8 = 0;
    @(posedge clk); #1;
    total += 3;
    if (rdy8 !== 1'b0) begin bad++; $display("FAIL w8_drop_rdy got=%b exp=0", rdy8); end
    if (bsy8 !== 1'b0) begin bad++; $display("FAIL w8_drop_busy got=%b exp=0", bsy8); end
    if (res8 !== 16'h0F0F) begin bad++; $display("FAIL w8_drop_res got=%h exp=0f0f", res8); end
    run8(8'h80, 8'hFF, 1'b1, res, lat);
    total += 2;
    if (res !== 16'h0080) begin bad++; $display("FAIL w8_min_res got=%h exp=0080", res); end
    if (lat !== 9) begin bad++; $display("FAIL w8_min_lat got=%0d exp=9", lat); end
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      s = 1'($urandom_range(0, 1));
      exp = ref8(a, b, s);
      run8(a, b, s, res, lat);
      total += 2;
      if (res !== exp) begin bad++; $display("FAIL rnd8_%0d_res a=%h b=%h s=%b got=%h exp=%h", i, a, b, s, res, exp); end
      if (lat !== ((b == 0) ? 2 : 9)) begin bad++; $display("FAIL rnd8_%0d_lat got=%0d", i, lat); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] res;
    int lat, bc;
    for (int i = 1; i <= 3; i++) begin
      run32(32'd1000 * i, 32'd13, 1'b0, res, lat, bc);
      total += 2;
      if (res !== ref32(32'd1000 * i, 32'd13, 1'b0)) begin
        bad++; $display("FAIL b2b%0d_res got=%h exp=%h", i, res, ref32(32'd1000 * i, 32'd13, 1'b0));
      end
      if (lat !== 33) begin bad++; $display("FAIL b2b%0d_lat got=%0d exp=33", i, lat); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_byzero();
    test_annul();
    test_random32();
    test_width8();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Parametrised iterative integer divider for the EX stage of the pipeline. It computes quotient and remainder for signed or unsigned operands of width WIDTH using one restoring-division step per cycle. Its results feed the hi/lo write path: quotient goes to lo, remainder to hi. While an operation is in progress, EX raises its stall request so the stall controller freezes the earlier stages.

## Interface
- WIDTH, 32: operand width in bits; must be at least 2.
- CNT_W, $clog2(WIDTH+1): iteration-counter width. Derived; do not override.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  request a divide; held high by EX until ready_o is seen.
- signed_i  in  1  1 = two's-complement operands, 0 = unsigned. Sampled with start_i.
- opdata1_i  in  WIDTH  dividend. Sampled with start_i.
- opdata2_i  in  WIDTH  divisor. Sampled with start_i.
- annul_i  in  1  abort the current operation (pipeline flush).
- result_o  out  2*WIDTH  {remainder, quotient}.
- ready_o  out  1  result_o is valid.
- busy_o  out  1  an operation is in flight (state BYZERO or ON).

## Operation
- FSM states: FREE, BYZERO, ON, END. All outputs are registered.
- Reset:
  - state = FREE, counter = 0.
  - result_o = 0, ready_o = 0, busy_o = 0.
- FREE:
  - If start_i=1 and annul_i=0, latch the operands and sign flags.
  - Go to BYZERO if opdata2_i == 0, otherwise go to ON.
  - Signed mode: latch |opdata1_i| and |opdata2_i|. Record neg_q = sign1 XOR sign2 and neg_r = sign1.
- BYZERO: load result = 0, then go to END.
- ON: one restoring step per cycle.
  - Compute trial = partial_remainder − divisor, (WIDTH+1) bits wide.
  - If trial is non-negative: shift in quotient bit 1 and keep trial as the partial remainder.
  - Otherwise: shift in quotient bit 0 and keep the partial remainder unchanged.
  - After WIDTH steps (counter 0..WIDTH−1), apply the sign fix-up to the magnitudes:
    - negate the quotient if neg_q;
    - negate the remainder if neg_r.
  - Write result_o, then go to END.
- END: ready_o = 1 and result_o is stable.
  - Stay in END while start_i=1.
  - When start_i=0, go to FREE and clear ready_o. result_o keeps its value until the next result load.
- annul_i=1 in any state:
  - next state = FREE, ready_o = 0, busy_o = 0;
  - result_o is not updated.
  - annul_i takes priority over start_i when both are high in the same cycle.
- Arithmetic:
  - Truncation is toward zero.
  - The remainder takes the sign of the dividend.
  - Signed MIN / −1 gives quotient = MIN and remainder = 0 (no trap).
- EX stall request is start_i & ~ready_o, formed in EX. It covers the FREE cycle before busy_o rises.

## Timing
- Let cycle N be the cycle in which start_i is sampled in FREE.
- Normal divide: ON occupies cycles N+1 .. N+WIDTH. END and ready_o=1 start at cycle N+WIDTH+1. For WIDTH=32 this is 33 cycles after start.
- Divide by zero: BYZERO at N+1; END and ready_o=1 at N+2.
- busy_o is high exactly during the BYZERO and ON cycles.
- Back-to-back operations need one FREE cycle between them: start_i must drop for at least one cycle.
- Annul at cycle M gives state FREE at M+1. A new start_i can be accepted at M+1.

## Structure
- The shared defines package holds:
  - state encodings DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END (2 bits);
  - DivStart / DivStop and DivResultReady / DivResultNotReady constants.
- Sub-module div_step: purely combinational. Inputs are the partial remainder, dividend and divisor. Outputs are the next partial remainder and the quotient bit.
- The FSM, counter and sign fix-up stay in div_unit.

## Test plan
- Unsigned, WIDTH=32: 100 / 7 → result_o = {0x00000002, 0x0000000E}. ready_o rises exactly 33 cycles after start.
- Signed: −100 / 7 → quotient 0xFFFFFFF2, remainder 0xFFFFFFFE. 100 / −7 → quotient 0xFFFFFFF2, remainder 0x00000002.
- Divide by zero (0x1234 / 0) → ready_o high at N+2 with result_o = 0. busy_o is high for exactly 1 cycle.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- annul_i pulsed at iteration 10 → FREE on the next cycle, ready_o never rises, result_o unchanged. A new start on the following cycle completes correctly.
- WIDTH=8 instance with unsigned 255 / 16 → {15, 15}, ready after 9 cycles. Also check that holding start_i keeps END and ready_o=1, and that dropping start_i returns to FREE.
